// File: rtl/activation_pkg.sv
// Shared definitions for the activation-function LUT loaders (tanh, sigmoid).
// Contents: fixed-point defaults and the loader FSM state type.
package activation_pkg;

  localparam int N_DEF = 32;  // fixed-point total width
  localparam int Q_DEF = 16;  // fractional bits

  // 1.0 in Q16.16
  localparam logic [N_DEF-1:0] ONE_Q16 = 32'(1) << Q_DEF;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/lut_entry_check.sv
// Combinational validity check for one LUT entry.
// Ports:
//   data       - candidate entry (signed fixed point, Q fractional bits)
//   prev       - previously accepted entry
//   first_flag - data is the first entry of the table (no monotonic check)
//   range_bad  - entry is negative or greater than 1.0
//   mono_bad   - entry is below the previous entry (signed compare)
module lut_entry_check #(
  parameter int DW = 32,
  parameter int Q  = 16
) (
  input  logic [DW-1:0] data,
  input  logic [DW-1:0] prev,
  input  logic          first_flag,
  output logic          range_bad,
  output logic          mono_bad
);

  localparam logic [DW-1:0] ONE = DW'(1) << Q;

  // Sign is tested first, so the unsigned compare only sees non-negative values.
  assign range_bad = data[DW-1] | (data > ONE);
  assign mono_bad  = !first_flag && ($signed(data) < $signed(prev));

endmodule

// File: rtl/tanh_lut_loader.sv
// Loads the tanh activation LUT from a valid/ready stream of Q16.16 entries.
// Entries are written sequentially to addresses 0..2^AW-1 with one cycle of
// registered latency; each entry is range- and monotonic-checked and summed.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start / abort       - single-cycle control pulses
//   s_valid/s_data/s_ready - entry stream handshake
//   mem_we/mem_addr/mem_wdata - LUT RAM write port
//   busy, done          - LOAD / DONE state indicators
//   range_err, mono_err - sticky entry validation flags
//   checksum, count     - mod-2^DW sum and number of entries since start
module tanh_lut_loader
  import activation_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int N  = N_DEF,
  parameter int Q  = Q_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          range_err,
  output logic          mono_err,
  output logic [DW-1:0] checksum,
  output logic [AW:0]   count
);

  localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

  loader_state_e state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [N-1:0]  sum_q, sum_d;       // N equals DW
  logic          rerr_q, rerr_d;
  logic          merr_q, merr_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic accept;
  logic range_bad, mono_bad;

  lut_entry_check #(
    .DW (DW),
    .Q  (Q)
  ) u_check (
    .data       (s_data),
    .prev       (prev_q),
    .first_flag (count_q == '0),
    .range_bad  (range_bad),
    .mono_bad   (mono_bad)
  );

  assign s_ready = (state_q == LD_LOAD) && !abort;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    rerr_d  = rerr_q;
    merr_d  = merr_q;
    prev_d  = prev_q;
    we_d    = accept;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (accept) begin
      addr_d  = count_q[AW-1:0];
      wdata_d = s_data;
    end

    unique case (state_q)
      LD_IDLE, LD_DONE: begin
        if (start) begin
          state_d = LD_LOAD;
          count_d = '0;
          sum_d   = '0;
          rerr_d  = 1'b0;
          merr_d  = 1'b0;
        end
      end
      LD_LOAD: begin
        // accept is already gated by !abort, so abort simply exits
        if (abort) begin
          state_d = LD_IDLE;
        end else if (accept) begin
          count_d = count_q + 1'b1;
          sum_d   = sum_q + N'(s_data);
          rerr_d  = rerr_q | range_bad;
          merr_d  = merr_q | mono_bad;
          prev_d  = s_data;
          if (count_q == LAST) state_d = LD_DONE;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      count_q <= '0;
      sum_q   <= '0;
      rerr_q  <= 1'b0;
      merr_q  <= 1'b0;
      prev_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      rerr_q  <= rerr_d;
      merr_q  <= merr_d;
      prev_q  <= prev_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == LD_LOAD);
  assign done      = (state_q == LD_DONE);
  assign range_err = rerr_q;
  assign mono_err  = merr_q;
  assign checksum  = sum_q;
  assign count     = count_q;

endmodule

// File: tb/tb_tanh_lut_loader.sv
// Testbench for tanh_lut_loader: randomized stream timing and control pulses,
// compared each cycle against a table-level reference model.
module tb_tanh_lut_loader;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready, mem_we, busy, done, range_err, mono_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, checksum;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  tanh_lut_loader #(
    .AW (AW),
    .DW (DW),
    .N  (32),
    .Q  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .range_err (range_err),
    .mono_err  (mono_err),
    .checksum  (checksum),
    .count     (count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: loader mode plus table-level bookkeeping.
  typedef enum {M_IDLE, M_LOAD, M_DONE} mode_t;
  mode_t       m;
  int unsigned m_cnt;
  logic [31:0] m_sum, m_prev;
  bit          m_rerr, m_merr;
  bit          pend;
  int unsigned pend_addr;
  logic [31:0] pend_data;
  bit          last_acc;

  logic [31:0] rnd_tab [DEPTH];

  function automatic logic [31:0] gen(input int kind, input int i);
    case (kind)
      0: return 32'(i * 64);
      1: begin
        if (i == 5) return 32'h0001_0001;
        if (i == 9) return 32'hFFFF_0000;
        return 32'(i * 64);
      end
      2: begin
        if (i < 10)  return 32'(i * 256);
        if (i == 10) return 32'h0000_0050;
        return 32'(32'h50 + (i - 10) * 64);
      end
      default: return rnd_tab[i];
    endcase
  endfunction

  task automatic model_reset();
    m      = M_IDLE;
    m_cnt  = 0;
    m_sum  = '0;
    m_prev = '0;
    m_rerr = 0;
    m_merr = 0;
    pend   = 0;
  endtask

  // One clock cycle: check registered outputs mid-cycle, drive inputs,
  // check s_ready, then advance the model as the coming edge will.
  task automatic step(input bit v, input logic [31:0] d, input bit st, input bit ab);
    bit exp_ready;
    @(negedge clk);
    check("mem_we", 32'(mem_we), 32'(pend));
    if (pend) begin
      check("mem_addr", 32'(mem_addr), pend_addr);
      check("mem_wdata", mem_wdata, pend_data);
    end
    check("busy", 32'(busy), 32'(m == M_LOAD));
    check("done", 32'(done), 32'(m == M_DONE));
    check("count", 32'(count), m_cnt);
    check("checksum", checksum, m_sum);
    check("range_err", 32'(range_err), 32'(m_rerr));
    check("mono_err", 32'(mono_err), 32'(m_merr));

    s_valid = v;
    s_data  = d;
    start   = st;
    abort   = ab;
    #1;
    exp_ready = (m == M_LOAD) && !ab;
    check("s_ready", 32'(s_ready), 32'(exp_ready));

    last_acc = v && exp_ready;
    pend     = last_acc;
    if (last_acc) begin
      pend_addr = m_cnt;
      pend_data = d;
      if ($signed(d) < 0 || $signed(d) > 65536) m_rerr = 1;
      if (m_cnt != 0 && $signed(d) < $signed(m_prev)) m_merr = 1;
      m_prev = d;
      m_sum  = m_sum + d;
      m_cnt++;
    end

    case (m)
      M_LOAD: begin
        if (ab) m = M_IDLE;
        else if (m_cnt == DEPTH) m = M_DONE;
      end
      default: begin
        if (st) begin
          m      = M_LOAD;
          m_cnt  = 0;
          m_sum  = '0;
          m_rerr = 0;
          m_merr = 0;
        end
      end
    endcase
  endtask

  task automatic apply_reset();
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    s_data  = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_range_err", 32'(range_err), 0);
    check("rst_mono_err", 32'(mono_err), 0);
    check("rst_checksum", checksum, 0);
    check("rst_count", 32'(count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // stop_kind: 0 = run to completion, 1 = start+abort at stop_at, 2 = reset at stop_at
  task automatic run_load(input int kind, input int gap, input int stop_at, input int stop_kind);
    int idx = 0;
    int guard = 0;
    bit stopped = 0;
    step(1'b0, '0, 1'b1, 1'b0);
    while (idx < DEPTH && !stopped && guard < 20000) begin
      if (stop_kind != 0 && idx == stop_at) begin
        if (stop_kind == 1) step(1'b1, gen(kind, idx), 1'b1, 1'b1);
        else apply_reset();
        stopped = 1;
      end else begin
        step($urandom_range(0, 99) >= 32'(gap), gen(kind, idx),
             $urandom_range(0, 39) == 0, 1'b0);
        if (last_acc) idx++;
        guard++;
      end
    end
    if (!stopped) check("load_len", 32'(idx), DEPTH);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 63) == 0) rnd_tab[i] = -32'($urandom_range(0, 999));
      else rnd_tab[i] = $urandom_range(0, 32'h0001_0400);
    end

    apply_reset();
    step(1'b0, '0, 1'b0, 1'b1);  // abort in IDLE is ignored

    run_load(0, 0, 0, 0);
    check("ramp_count", 32'(count), 32'd1024);
    check("ramp_checksum", checksum, 32'h01FF_8000);
    check("ramp_done", 32'(done), 1);
    check("ramp_flags", {30'd0, range_err, mono_err}, 0);

    run_load(0, 30, 0, 0);
    check("gap_checksum", checksum, 32'h01FF_8000);
    check("gap_done", 32'(done), 1);

    run_load(1, 10, 0, 0);
    check("range_flag", 32'(range_err), 1);
    check("range_done", 32'(done), 1);

    run_load(2, 0, 0, 0);
    check("mono_flag", 32'(mono_err), 1);
    check("mono_range_clear", 32'(range_err), 0);

    run_load(0, 20, 500, 1);
    check("abort_count", 32'(count), 500);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);

    run_load(0, 0, 0, 0);
    check("reload_count", 32'(count), 32'd1024);
    check("reload_checksum", checksum, 32'h01FF_8000);
    check("reload_flags", {30'd0, range_err, mono_err}, 0);

    run_load(0, 10, 300, 2);
    check("reset_count", 32'(count), 0);

    run_load(3, 25, 0, 0);
    run_load(0, 5, 0, 0);
    check("final_checksum", checksum, 32'h01FF_8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
